// File: rtl/alu0_issue_queue_if.sv
// Dispatch and select buses of the ALU0 issue queue.
// slave = queue side, master = rename/dispatch plus register-read side.
interface alu0_issue_queue_if;
  logic        disp_vld;
  logic        disp_rdy;
  logic [4:0]  disp_op;
  logic [19:0] disp_imm;
  logic [5:0]  disp_dest;
  logic [5:0]  disp_src1;
  logic        disp_src1_rdy;
  logic [5:0]  disp_src2;
  logic        disp_src2_rdy;
  logic [5:0]  disp_ROB_ID;

  logic        ALU0_select_vld;
  logic [4:0]  ALU0_select_op;
  logic [19:0] ALU0_select_imm;
  logic [5:0]  ALU0_select_dest;
  logic [5:0]  ALU0_select_source1;
  logic [5:0]  ALU0_select_source2;
  logic [5:0]  ALU0_select_ROB_ID;

  modport slave (
    input  disp_vld, disp_op, disp_imm, disp_dest, disp_src1, disp_src1_rdy,
           disp_src2, disp_src2_rdy, disp_ROB_ID,
    output disp_rdy,
    output ALU0_select_vld, ALU0_select_op, ALU0_select_imm, ALU0_select_dest,
           ALU0_select_source1, ALU0_select_source2, ALU0_select_ROB_ID
  );

  modport master (
    output disp_vld, disp_op, disp_imm, disp_dest, disp_src1, disp_src1_rdy,
           disp_src2, disp_src2_rdy, disp_ROB_ID,
    input  disp_rdy,
    input  ALU0_select_vld, ALU0_select_op, ALU0_select_imm, ALU0_select_dest,
           ALU0_select_source1, ALU0_select_source2, ALU0_select_ROB_ID
  );
endinterface

// File: rtl/alu0_issue_queue.sv
// Compacting oldest-first issue queue for ALU0; select is combinational from registered state,
// dispatch backpressures only on a full queue (disp_rdy independent of same-cycle select).
module alu0_issue_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_stall,
  input  logic             BRU_wake_vld,
  input  logic [5:0]       BRU_wake_PR,
  input  logic             WB_wake_vld,
  input  logic [5:0]       WB_wake_PR,
  output logic [CNT_W-1:0] iq_count,
  alu0_issue_queue_if.slave iq
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  op;
    logic [19:0] imm;
    logic [5:0]  dest;
    logic [5:0]  src1;
    logic [5:0]  src2;
    logic        rdy1;
    logic        rdy2;
    logic [5:0]  rob_id;
  } entry_t;

  entry_t           q   [DEPTH];
  entry_t           w   [DEPTH];
  entry_t           nq  [DEPTH];
  entry_t           din;
  logic             sel_found;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic [DEPTH-1:0] shift_mask;
  logic             disp_acc;
  logic             imm_op;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic wake_hit(input logic [5:0] tag,
                                    input logic a_vld, input logic [5:0] a_pr,
                                    input logic b_vld, input logic [5:0] b_pr,
                                    input logic c_vld, input logic [5:0] c_pr);
    return (a_vld && a_pr == tag) || (b_vld && b_pr == tag) || (c_vld && c_pr == tag);
  endfunction

  // Oldest-ready pick; shift_mask marks the selected slot and everything above it.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    shift_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && (CNT_W'(i) < iq_count) && q[i].rdy1 && q[i].rdy2) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      shift_mask[i] = sel_found;
    end
    sel_vld = sel_found && !issue_stall && !flush;
  end

  assign iq.ALU0_select_vld     = sel_vld;
  assign iq.ALU0_select_op      = q[sel_idx].op;
  assign iq.ALU0_select_imm     = q[sel_idx].imm;
  assign iq.ALU0_select_dest    = q[sel_idx].dest;
  assign iq.ALU0_select_source1 = q[sel_idx].src1;
  assign iq.ALU0_select_source2 = q[sel_idx].src2;
  assign iq.ALU0_select_ROB_ID  = q[sel_idx].rob_id;
  assign iq.disp_rdy            = (iq_count < CNT_W'(DEPTH));

  always_comb begin
    imm_op = 1'b0;
    case (iq.disp_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd21, 5'd22, 5'd23: imm_op = 1'b1;
      default: imm_op = 1'b0;
    endcase
  end

  always_comb begin
    disp_acc = iq.disp_vld && iq.disp_rdy && !flush;
    wr_idx   = iq_count - CNT_W'(sel_vld);
    cnt_next = iq_count + CNT_W'(disp_acc) - CNT_W'(sel_vld);

    // Wakeup also covers the micro-op dispatched this cycle.
    din.op     = iq.disp_op;
    din.imm    = iq.disp_imm;
    din.dest   = iq.disp_dest;
    din.src1   = iq.disp_src1;
    din.src2   = iq.disp_src2;
    din.rob_id = iq.disp_ROB_ID;
    din.rdy1   = iq.disp_src1_rdy ||
                 wake_hit(iq.disp_src1, sel_vld, iq.ALU0_select_dest,
                          BRU_wake_vld, BRU_wake_PR, WB_wake_vld, WB_wake_PR);
    din.rdy2   = imm_op || iq.disp_src2_rdy ||
                 wake_hit(iq.disp_src2, sel_vld, iq.ALU0_select_dest,
                          BRU_wake_vld, BRU_wake_PR, WB_wake_vld, WB_wake_PR);

    for (int i = 0; i < DEPTH; i++) begin
      w[i]      = q[i];
      w[i].rdy1 = q[i].rdy1 ||
                  wake_hit(q[i].src1, sel_vld, iq.ALU0_select_dest,
                           BRU_wake_vld, BRU_wake_PR, WB_wake_vld, WB_wake_PR);
      w[i].rdy2 = q[i].rdy2 ||
                  wake_hit(q[i].src2, sel_vld, iq.ALU0_select_dest,
                           BRU_wake_vld, BRU_wake_PR, WB_wake_vld, WB_wake_PR);
    end

    for (int i = 0; i < DEPTH - 1; i++) begin
      nq[i] = (sel_vld && shift_mask[i]) ? w[i+1] : w[i];
    end
    nq[DEPTH-1] = w[DEPTH-1];

    for (int i = 0; i < DEPTH; i++) begin
      if (disp_acc && wr_idx == CNT_W'(i)) nq[i] = din;
    end
  end

  // Payload needs no reset: only slots below iq_count are ever considered.
  always_ff @(posedge clk) begin
    q <= nq;
    if (rst || flush) iq_count <= '0;
    else              iq_count <= cnt_next;
  end
endmodule

// File: tb/tb_alu0_issue_queue.sv
// Directed bench for alu0_issue_queue: expected issues go into a scoreboard queue,
// a negedge monitor pops and compares whenever ALU0_select_vld is high.
module tb_alu0_issue_queue;
  logic       clk = 1'b0;
  logic       rst, flush, issue_stall;
  logic       BRU_wake_vld, WB_wake_vld;
  logic [5:0] BRU_wake_PR, WB_wake_PR;
  logic [3:0] iq_count;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [48:0] sb [$];
  logic [48:0] mon_exp;

  always #5 clk = ~clk;

  alu0_issue_queue_if ifc ();

  alu0_issue_queue #(.DEPTH(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_stall  (issue_stall),
    .BRU_wake_vld (BRU_wake_vld),
    .BRU_wake_PR  (BRU_wake_PR),
    .WB_wake_vld  (WB_wake_vld),
    .WB_wake_PR   (WB_wake_PR),
    .iq_count     (iq_count),
    .iq           (ifc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [48:0] pk(input logic [4:0] op, input logic [19:0] imm,
                                     input logic [5:0] dest, input logic [5:0] s1,
                                     input logic [5:0] s2, input logic [5:0] rob);
    return {op, imm, dest, s1, s2, rob};
  endfunction

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [4:0] op, input logic [19:0] imm, input logic [5:0] dest,
                          input logic [5:0] s1, input logic r1,
                          input logic [5:0] s2, input logic r2, input logic [5:0] rob);
    ifc.disp_vld      = 1'b1;
    ifc.disp_op       = op;
    ifc.disp_imm      = imm;
    ifc.disp_dest     = dest;
    ifc.disp_src1     = s1;
    ifc.disp_src1_rdy = r1;
    ifc.disp_src2     = s2;
    ifc.disp_src2_rdy = r2;
    ifc.disp_ROB_ID   = rob;
  endtask

  always @(negedge clk) begin
    if (ifc.ALU0_select_vld === 1'b1) begin
      if (sb.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_issue: got dest %0d required no issue", ifc.ALU0_select_dest);
      end else begin
        mon_exp = sb.pop_front();
        chk("issue_fields",
            {15'd0, ifc.ALU0_select_op, ifc.ALU0_select_imm, ifc.ALU0_select_dest,
             ifc.ALU0_select_source1, ifc.ALU0_select_source2, ifc.ALU0_select_ROB_ID},
            {15'd0, mon_exp});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; issue_stall = 1'b0;
    BRU_wake_vld = 1'b0; BRU_wake_PR = '0; WB_wake_vld = 1'b0; WB_wake_PR = '0;
    set_disp(5'd0, 20'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
    ifc.disp_vld = 1'b0;
    tick; tick;
    rst = 1'b0; #3;
    chk("rst_count", iq_count, 0);
    chk("rst_disp_rdy", ifc.disp_rdy, 1);
    chk("rst_sel_vld", ifc.ALU0_select_vld, 0);

    // Fill with unready ops, then try a 9th.
    for (int i = 0; i < 8; i++) begin
      tick;
      set_disp(5'd7, 20'(i), 6'(16 + i), 6'(40 + i), 1'b0, 6'(50 + i), 1'b0, 6'(i));
    end
    tick;
    set_disp(5'd7, 20'd9, 6'd30, 6'd48, 1'b0, 6'd58, 1'b0, 6'd9);
    #3;
    chk("full_count", iq_count, 8);
    chk("full_disp_rdy", ifc.disp_rdy, 0);
    chk("full_sel_vld", ifc.ALU0_select_vld, 0);
    tick;
    ifc.disp_vld = 1'b0; #3;
    chk("full_9th_rejected", iq_count, 8);

    // Reset mid-operation.
    tick; rst = 1'b1;
    tick; rst = 1'b0; #3;
    chk("midrst_count", iq_count, 0);
    chk("midrst_disp_rdy", ifc.disp_rdy, 1);

    // A then B resident under stall; release gives back-to-back issue via select wakeup.
    sb.push_back(pk(5'd7, 20'h111, 6'd10, 6'd5, 6'd6, 6'd1));
    sb.push_back(pk(5'd7, 20'h222, 6'd11, 6'd10, 6'd6, 6'd2));
    tick; issue_stall = 1'b1;
    set_disp(5'd7, 20'h111, 6'd10, 6'd5, 1'b1, 6'd6, 1'b1, 6'd1);
    tick;
    set_disp(5'd7, 20'h222, 6'd11, 6'd10, 1'b0, 6'd6, 1'b1, 6'd2);
    #3; chk("ab_stall_vld", ifc.ALU0_select_vld, 0);
    tick; ifc.disp_vld = 1'b0; issue_stall = 1'b0; #3;
    chk("b2b_first_vld", ifc.ALU0_select_vld, 1);
    tick; #3;
    chk("b2b_second_vld", ifc.ALU0_select_vld, 1);
    tick; #3;
    chk("b2b_done_vld", ifc.ALU0_select_vld, 0);
    chk("b2b_done_count", iq_count, 0);

    // Oldest-ready selection, immediate-op rdy2, BRU wakeup.
    sb.push_back(pk(5'd9, 20'h5, 6'd41, 6'd1, 6'd2, 6'd4));
    sb.push_back(pk(5'd3, 20'hABCDE, 6'd42, 6'd1, 6'd0, 6'd5));
    sb.push_back(pk(5'd8, 20'h0, 6'd40, 6'd30, 6'd31, 6'd3));
    tick; set_disp(5'd8, 20'h0, 6'd40, 6'd30, 1'b0, 6'd31, 1'b1, 6'd3);
    tick; set_disp(5'd9, 20'h5, 6'd41, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4);
    #3; chk("e0_not_ready", ifc.ALU0_select_vld, 0);
    tick; set_disp(5'd3, 20'hABCDE, 6'd42, 6'd1, 1'b1, 6'd0, 1'b0, 6'd5);
    #3; chk("e1_sel_vld", ifc.ALU0_select_vld, 1);
    tick; ifc.disp_vld = 1'b0; #3;
    chk("e2_imm_sel_vld", ifc.ALU0_select_vld, 1);
    tick; #3;
    chk("e0_wait_vld", ifc.ALU0_select_vld, 0);
    chk("e0_wait_count", iq_count, 1);
    tick; BRU_wake_vld = 1'b1; BRU_wake_PR = 6'd30; #3;
    chk("bru_cycle_vld", ifc.ALU0_select_vld, 0);
    tick; BRU_wake_vld = 1'b0; #3;
    chk("bru_wake_sel_vld", ifc.ALU0_select_vld, 1);
    tick; #3;
    chk("e_done_count", iq_count, 0);

    // Writeback wakeup on the dispatching micro-op.
    sb.push_back(pk(5'd10, 20'h77, 6'd43, 6'd20, 6'd21, 6'd6));
    tick; set_disp(5'd10, 20'h77, 6'd43, 6'd20, 1'b0, 6'd21, 1'b1, 6'd6);
    WB_wake_vld = 1'b1; WB_wake_PR = 6'd20; #3;
    chk("wb_empty_vld", ifc.ALU0_select_vld, 0);
    tick; ifc.disp_vld = 1'b0; WB_wake_vld = 1'b0; #3;
    chk("wb_bypass_vld", ifc.ALU0_select_vld, 1);
    tick; #3;
    chk("wb_done_count", iq_count, 0);

    // Stall holds three ready entries; release issues them in order.
    sb.push_back(pk(5'd12, 20'h1, 6'd50, 6'd2, 6'd3, 6'd7));
    sb.push_back(pk(5'd13, 20'h2, 6'd51, 6'd2, 6'd3, 6'd8));
    sb.push_back(pk(5'd14, 20'h3, 6'd52, 6'd2, 6'd3, 6'd9));
    tick; issue_stall = 1'b1;
    set_disp(5'd12, 20'h1, 6'd50, 6'd2, 1'b1, 6'd3, 1'b1, 6'd7);
    tick; set_disp(5'd13, 20'h2, 6'd51, 6'd2, 1'b1, 6'd3, 1'b1, 6'd8);
    tick; set_disp(5'd14, 20'h3, 6'd52, 6'd2, 1'b1, 6'd3, 1'b1, 6'd9);
    for (int c = 0; c < 2; c++) begin
      tick; ifc.disp_vld = 1'b0; #3;
      chk("stall_vld", ifc.ALU0_select_vld, 0);
      chk("stall_count", iq_count, 3);
    end
    tick; issue_stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3; chk("stall_release_vld", ifc.ALU0_select_vld, 1);
      tick;
    end
    #3;
    chk("stall_done_count", iq_count, 0);

    // Flush beats dispatch and select.
    tick; issue_stall = 1'b1;
    set_disp(5'd15, 20'h0, 6'd60, 6'd2, 1'b1, 6'd3, 1'b1, 6'd10);
    tick; issue_stall = 1'b0; flush = 1'b1;
    set_disp(5'd16, 20'h0, 6'd61, 6'd2, 1'b1, 6'd3, 1'b1, 6'd11);
    #3;
    chk("flush_pre_count", iq_count, 1);
    chk("flush_sel_vld", ifc.ALU0_select_vld, 0);
    tick; flush = 1'b0; ifc.disp_vld = 1'b0; #3;
    chk("flush_count", iq_count, 0);
    chk("flush_disp_rdy", ifc.disp_rdy, 1);
    chk("flush_after_vld", ifc.ALU0_select_vld, 0);

    tick;
    chk("sb_drain", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
